// File: rtl/snow64_multicycle_shifter.sv
// -----------------------------------------------------------------------------
// snow64_multicycle_shifter
//
// Multi-cycle barrel shifter for the snow64 ALU. Performs LSL, LSR, ASR and ROR
// on a power-of-two data width. Each BUSY cycle resolves BITS_PER_CYCLE bits of
// the shift amount, so one result takes NUM_STEPS cycles.
//
// Handshake:
//   A request is accepted on a rising edge where in_valid && out_ready.
//   out_ready is high only in IDLE. A result is presented with out_valid held
//   high in DONE until a rising edge with in_result_ready high retires it.
//   in_valid is ignored outside IDLE, and in_result_ready is ignored outside
//   DONE. Inputs are sampled only on the accept edge.
//
// Optional feature (macro SNOW64_SHIFTER_EARLY_DONE_EN):
//   When defined, the shifter goes to DONE as soon as every amount bit that
//   has not yet been applied is zero. Results are identical; only latency
//   changes. When undefined, latency is always NUM_STEPS.
//
// Parameters:
//   WIDTH__DATA_INOUT  data width, power of two, 2..64
//   BITS_PER_CYCLE     amount bits resolved per BUSY cycle, 1..$clog2(width)
//
// Ports:
//   clk              clock, rising edge
//   rst_n            asynchronous reset, active low
//   in_valid         request valid
//   out_ready        request accepted when high (IDLE only)
//   in_op            0=LSL 1=LSR 2=ASR 3=ROR
//   in_to_shift      operand
//   in_amount        shift amount, unsigned
//   out_valid        result valid, held until taken
//   in_result_ready  downstream takes result
//   out_data         registered result
//   out_busy         high in BUSY or DONE
// -----------------------------------------------------------------------------
module snow64_multicycle_shifter #(
  parameter int WIDTH__DATA_INOUT = 64,
  parameter int BITS_PER_CYCLE    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         out_ready,
  input  logic [1:0]                   in_op,
  input  logic [WIDTH__DATA_INOUT-1:0] in_to_shift,
  input  logic [WIDTH__DATA_INOUT-1:0] in_amount,
  output logic                         out_valid,
  input  logic                         in_result_ready,
  output logic [WIDTH__DATA_INOUT-1:0] out_data,
  output logic                         out_busy
);

  localparam int W         = WIDTH__DATA_INOUT;
  localparam int LOG2_W    = $clog2(W);
  localparam int BPC       = BITS_PER_CYCLE;
  localparam int NUM_STEPS = (LOG2_W + BPC - 1) / BPC;
  localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  localparam logic [1:0] OP_LSL = 2'd0;
  localparam logic [1:0] OP_LSR = 2'd1;
  localparam logic [1:0] OP_ASR = 2'd2;
  localparam logic [1:0] OP_ROR = 2'd3;

  // Elaboration-time parameter guards.
  if (W < 2 || W > 64 || (W & (W - 1)) != 0) begin : g_bad_width
    $error("WIDTH__DATA_INOUT must be a power of two in 2..64");
  end
  if (BPC < 1 || BPC > LOG2_W) begin : g_bad_bpc
    $error("BITS_PER_CYCLE must be in 1..$clog2(WIDTH__DATA_INOUT)");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [1:0]          op_q;
  logic [W-1:0]        data_q;
  logic [LOG2_W-1:0]   amt_q;
  logic [STEP_W-1:0]   step_q;

  // ---------------------------------------------------------------------------
  // Accept-time normalisation: out-of-range amounts are folded into the
  // operand so the BUSY datapath only ever sees amounts below W.
  // ---------------------------------------------------------------------------
  logic              saturated;
  logic [W-1:0]      eff_operand;
  logic [LOG2_W-1:0] eff_amt;

  always_comb begin
    saturated   = |in_amount[W-1:LOG2_W];
    eff_operand = in_to_shift;
    eff_amt     = in_amount[LOG2_W-1:0];
    if (in_op != OP_ROR && saturated) begin
      eff_amt     = '0;
      eff_operand = (in_op == OP_ASR) ? {W{in_to_shift[W-1]}} : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-step datapath: shift by the amount bits owned by the current step,
  // kept in their original bit positions so their weight is preserved.
  // ---------------------------------------------------------------------------
  logic [LOG2_W-1:0] step_mask;
  logic [LOG2_W-1:0] step_sh;
  logic [W-1:0]      next_data;
  logic              last_step;
  logic              finish;

  always_comb begin
    step_mask = LOG2_W'({BPC{1'b1}}) << (int'(step_q) * BPC);
    step_sh   = amt_q & step_mask;
    next_data = data_q;
    case (op_q)
      OP_LSL:  next_data = data_q << step_sh;
      OP_LSR:  next_data = data_q >> step_sh;
      // Operand MSB never changes under ASR, so it is the latched fill bit.
      OP_ASR:  next_data = $unsigned($signed(data_q) >>> step_sh);
      // A zero amount shifts left by W, which yields zero, so the OR is safe.
      default: next_data = (data_q >> step_sh) | (data_q << (W - int'(step_sh)));
    endcase
    last_step = (step_q == STEP_W'(NUM_STEPS - 1));
`ifdef SNOW64_SHIFTER_EARLY_DONE_EN
    // Finish once no higher amount bits remain to be applied.
    finish = last_step || ((amt_q >> ((int'(step_q) + 1) * BPC)) == '0);
`else
    finish = last_step;
`endif
  end

  // ---------------------------------------------------------------------------
  // Control FSM and registered datapath.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      data_q   <= '0;
      amt_q    <= '0;
      step_q   <= '0;
      out_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q   <= in_op;
            data_q <= eff_operand;
            amt_q  <= eff_amt;
            step_q <= '0;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          data_q <= next_data;
          step_q <= step_q + STEP_W'(1);
          if (finish) begin
            out_data <= next_data;
            step_q   <= '0;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (in_result_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_ready = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_busy  = (state != ST_IDLE);

endmodule
